clock_disp_scan: RTL and testbench

//  Downstream of the time-of-day counter: takes binary hour/minute/second and drives a 6-digit

---
 rtl/clock_disp_scan_if.sv | 23 ++
 rtl/clock_disp_scan.sv | 162 ++++++++++++++++
 tb/tb_clock_disp_scan.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/clock_disp_scan_if.sv
// Signal bundle between the time-of-day source and the 7-segment scan driver.
// The master side supplies time and enable; the slave side drives the display.
interface clock_disp_scan_if;
    logic [6:0] second;
    logic [6:0] minute;
    logic [6:0] hour;
    logic       disp_en;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;
    logic       range_err;

    modport master (
        output second, minute, hour, disp_en,
        input  an, seg, dp, frame_done, range_err
    );

    modport slave (
        input  second, minute, hour, disp_en,
        output an, seg, dp, frame_done, range_err
    );
endinterface

// File: rtl/clock_disp_scan.sv
// 6-digit multiplexed common-anode display driver (HH.MM.SS).
// The time is snapshotted once per scan frame so a frame never mixes two times;
// each slot starts with a short all-anodes-off window to suppress ghosting.
module clock_disp_scan #(
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 1000,
    parameter int BLANK_LEAD = 1,
    parameter int DP_BLINK   = 1
) (
    input  logic               clk,
    input  logic               rst,
    clock_disp_scan_if.slave   bus
);

    localparam int             CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  BLANK_V  = CW'(BLANK_CYC);

    logic [CW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [6:0]    snap_sec;
    logic [6:0]    snap_min;
    logic [6:0]    snap_hr;
    logic          tick;

    logic          sec_bad;
    logic          min_bad;
    logic          hr_bad;
    logic [7:0]    sec_bcd;
    logic [7:0]    min_bcd;
    logic [7:0]    hr_bcd;

    logic [3:0]    digit;
    logic          digit_bad;
    logic [5:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    logic [5:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          frame_done_q;
    logic          range_err_q;

    // Two-digit BCD of a value 0..59 using a compare chain for the tens digit.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        if      (v >= 7'd50) t = 4'd5;
        else if (v >= 7'd40) t = 4'd4;
        else if (v >= 7'd30) t = 4'd3;
        else if (v >= 7'd20) t = 4'd2;
        else if (v >= 7'd10) t = 4'd1;
        else                 t = 4'd0;
        return {t, 4'(v - 7'(t) * 7'd10)};
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for a decimal digit.
    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign tick    = (div_cnt == DIV_LAST);
    assign sec_bad = (snap_sec > 7'd59);
    assign min_bad = (snap_min > 7'd59);
    assign hr_bad  = (snap_hr  > 7'd23);
    assign sec_bcd = to_bcd(snap_sec);
    assign min_bcd = to_bcd(snap_min);
    assign hr_bcd  = to_bcd(snap_hr);

    // Slot divider, digit index and once-per-frame snapshot of the time inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt      <= '0;
            idx          <= 3'd0;
            snap_sec     <= 7'd0;
            snap_min     <= 7'd0;
            snap_hr      <= 7'd0;
            frame_done_q <= 1'b0;
            range_err_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (tick) begin
                div_cnt <= '0;
                if (idx == 3'd5) begin
                    idx          <= 3'd0;
                    snap_sec     <= bus.second;
                    snap_min     <= bus.minute;
                    snap_hr      <= bus.hour;
                    range_err_q  <= (bus.second > 7'd59) | (bus.minute > 7'd59) |
                                    (bus.hour > 7'd23);
                    frame_done_q <= 1'b1;
                end else begin
                    idx <= idx + 3'd1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Select the current digit, encode it and decide anode/dp for this cycle.
    always_comb begin
        digit     = 4'd0;
        digit_bad = 1'b0;
        case (idx)
            3'd0: begin digit = sec_bcd[3:0]; digit_bad = sec_bad; end
            3'd1: begin digit = sec_bcd[7:4]; digit_bad = sec_bad; end
            3'd2: begin digit = min_bcd[3:0]; digit_bad = min_bad; end
            3'd3: begin digit = min_bcd[7:4]; digit_bad = min_bad; end
            3'd4: begin digit = hr_bcd[3:0];  digit_bad = hr_bad;  end
            3'd5: begin digit = hr_bcd[7:4];  digit_bad = hr_bad;  end
            default: begin digit = 4'd0; digit_bad = 1'b0; end
        endcase

        seg_d = digit_bad ? 7'h3F : enc7(digit);
        if ((idx == 3'd5) && (BLANK_LEAD != 0) && !hr_bad && (hr_bcd[7:4] == 4'd0))
            seg_d = 7'h7F;

        dp_d = ~(((idx == 3'd2) || (idx == 3'd4)) && ((DP_BLINK == 0) || !snap_sec[0]));

        an_d = 6'h3F;
        if (bus.disp_en && (div_cnt >= BLANK_V))
            an_d = ~(6'(1) << idx);

        if (!bus.disp_en) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
    end

    // Register the display drive so pins change cleanly once per clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= 6'h3F;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
    assign bus.range_err  = range_err_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Bench for clock_disp_scan: two instances with opposite BLANK_LEAD/DP_BLINK
// settings, driven with the same time values and checked frame by frame.
module tb_clock_disp_scan;

    logic clk;
    logic rst;

    clock_disp_scan_if ifa();
    clock_disp_scan_if ifb();

    clock_disp_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .BLANK_LEAD(1), .DP_BLINK(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );

    clock_disp_scan #(.SCAN_DIV(4), .BLANK_CYC(1), .BLANK_LEAD(0), .DP_BLINK(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // seg fields packed {idx5,...,idx0}; dp masks are "dp lit" bits per idx.
    typedef struct {
        logic [6:0]  sec;
        logic [6:0]  min;
        logic [6:0]  hr;
        logic [41:0] seg_a;
        logic [41:0] seg_b;
        logic [5:0]  dp_a;
        logic [5:0]  dp_b;
        logic        rerr;
    } vec_t;

    vec_t vt[8];

    function automatic logic [41:0] s6(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic [6:0] s, input logic [6:0] m, input logic [6:0] h);
        ifa.second = s; ifa.minute = m; ifa.hour = h;
        ifb.second = s; ifb.minute = m; ifb.hour = h;
    endtask

    task automatic set_en(input logic e);
        ifa.disp_en = e;
        ifb.disp_en = e;
    endtask

    // Advance to the negedge where frame_done is seen; bounded.
    task automatic wait_frame();
        bit seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifa.frame_done) begin
                seen = 1;
                break;
            end
        end
        chk("frame_wait", 32'(seen), 32'd1);
    endtask

    // Starts right after a frame boundary (idx0, div_cnt 0) and checks all 24 cycles.
    task automatic check_frame(input string name, input logic [41:0] sa, input logic [41:0] sb,
                               input logic [5:0] da, input logic [5:0] db,
                               input int chg_slot, input logic [6:0] chg_sec);
        logic [5:0] exp_an;
        logic       exp_fd;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i == chg_slot && j == 0) begin
                    ifa.second = chg_sec;
                    ifb.second = chg_sec;
                end
                @(negedge clk);
                exp_an = (j >= 1) ? ~(6'(1) << i) : 6'h3F;
                exp_fd = (i == 5 && j == 3);
                chk($sformatf("%s_a_i%0d_c%0d", name, i, j),
                    32'({ifa.an, ifa.seg, ifa.dp, ifa.frame_done}),
                    32'({exp_an, sa[i*7 +: 7], ~da[i], exp_fd}));
                chk($sformatf("%s_b_i%0d_c%0d", name, i, j),
                    32'({ifb.an, ifb.seg, ifb.dp, ifb.frame_done}),
                    32'({exp_an, sb[i*7 +: 7], ~db[i], exp_fd}));
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_a"}, 32'({ifa.an, ifa.seg, ifa.dp, ifa.frame_done, ifa.range_err}),
            32'({6'h3F, 7'h7F, 1'b1, 1'b0, 1'b0}));
        chk({name, "_b"}, 32'({ifb.an, ifb.seg, ifb.dp, ifb.frame_done, ifb.range_err}),
            32'({6'h3F, 7'h7F, 1'b1, 1'b0, 1'b0}));
    endtask

    localparam logic [5:0] SEP = 6'b010100;

    logic [41:0] zero_a, zero_b, t12_a, t12_b, t13_a, t13_b;
    int          cnt;
    bit          dark_bad;

    initial begin
        zero_a = s6(7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        zero_b = s6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        t12_a  = s6(7'h7F, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24);
        t12_b  = s6(7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24);
        t13_a  = s6(7'h7F, 7'h40, 7'h40, 7'h40, 7'h79, 7'h30);
        t13_b  = s6(7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h30);

        vt[0] = '{7'd59, 7'd59, 7'd23,
                  s6(7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10),
                  s6(7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10), 6'b0, SEP, 1'b0};
        vt[1] = '{7'd8, 7'd34, 7'd5,
                  s6(7'h7F, 7'h12, 7'h30, 7'h19, 7'h40, 7'h00),
                  s6(7'h40, 7'h12, 7'h30, 7'h19, 7'h40, 7'h00), SEP, SEP, 1'b0};
        vt[2] = '{7'd7, 7'd0, 7'd5,
                  s6(7'h7F, 7'h12, 7'h40, 7'h40, 7'h40, 7'h78),
                  s6(7'h40, 7'h12, 7'h40, 7'h40, 7'h40, 7'h78), 6'b0, SEP, 1'b0};
        vt[3] = '{7'd60, 7'd12, 7'd10,
                  s6(7'h79, 7'h40, 7'h79, 7'h24, 7'h3F, 7'h3F),
                  s6(7'h79, 7'h40, 7'h79, 7'h24, 7'h3F, 7'h3F), SEP, SEP, 1'b1};
        vt[4] = '{7'd30, 7'd61, 7'd24,
                  s6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h30, 7'h40),
                  s6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h30, 7'h40), SEP, SEP, 1'b1};
        vt[5] = '{7'd30, 7'd0, 7'd0,
                  s6(7'h7F, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40),
                  s6(7'h40, 7'h40, 7'h40, 7'h40, 7'h30, 7'h40), SEP, SEP, 1'b0};
        vt[6] = '{7'd127, 7'd127, 7'd127,
                  s6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F),
                  s6(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), 6'b0, SEP, 1'b1};
        vt[7] = '{7'd45, 7'd7, 7'd19,
                  s6(7'h79, 7'h10, 7'h40, 7'h78, 7'h19, 7'h12),
                  s6(7'h79, 7'h10, 7'h40, 7'h78, 7'h19, 7'h12), 6'b0, SEP, 1'b0};

        // Reset held with the clock running, then released between edges.
        rst = 1'b0;
        set_en(1'b1);
        set_in(7'd0, 7'd0, 7'd0);
        repeat (3) @(negedge clk);
        check_reset_vals("reset_hold");
        rst = 1'b1;
        check_frame("first", zero_a, zero_b, SEP, SEP, -1, 7'd0);

        // Directed vectors: snapshot at the next boundary, then a full frame.
        for (int v = 0; v < 8; v++) begin
            set_in(vt[v].sec, vt[v].min, vt[v].hr);
            wait_frame();
            chk($sformatf("rerr_a_v%0d", v), 32'(ifa.range_err), 32'(vt[v].rerr));
            chk($sformatf("rerr_b_v%0d", v), 32'(ifb.range_err), 32'(vt[v].rerr));
            check_frame($sformatf("vec%0d", v), vt[v].seg_a, vt[v].seg_b,
                        vt[v].dp_a, vt[v].dp_b, -1, 7'd0);
        end

        // Input change mid-frame stays invisible until the next snapshot.
        set_in(7'd12, 7'd0, 7'd0);
        wait_frame();
        check_frame("hold12", t12_a, t12_b, SEP, SEP, 2, 7'd13);
        check_frame("next13", t13_a, t13_b, 6'b0, SEP, -1, 7'd0);

        // Display disabled mid-slot: dark next clock, scan keeps its cadence.
        repeat (5) @(negedge clk);
        set_en(1'b0);
        @(negedge clk);
        chk("dis_a", 32'({ifa.an, ifa.seg, ifa.dp}), 32'({6'h3F, 7'h7F, 1'b1}));
        chk("dis_b", 32'({ifb.an, ifb.seg, ifb.dp}), 32'({6'h3F, 7'h7F, 1'b1}));
        wait_frame();
        cnt = 0;
        dark_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cnt++;
            if ({ifa.an, ifa.seg, ifa.dp} != {6'h3F, 7'h7F, 1'b1} ||
                {ifb.an, ifb.seg, ifb.dp} != {6'h3F, 7'h7F, 1'b1})
                dark_bad = 1;
            if (ifa.frame_done) break;
        end
        chk("dis_period", 32'(cnt), 32'd24);
        chk("dis_dark", 32'(dark_bad), 32'd0);
        set_en(1'b1);
        check_frame("reen13", t13_a, t13_b, 6'b0, SEP, -1, 7'd0);

        // Asynchronous reset mid-frame with a bad snapshot loaded.
        set_in(7'd60, 7'd0, 7'd0);
        wait_frame();
        chk("rerr_pre_a", 32'(ifa.range_err), 32'd1);
        repeat (7) @(negedge clk);
        #1 rst = 1'b0;
        #1 check_reset_vals("reset_async");
        @(negedge clk);
        check_reset_vals("reset_async_hold");
        rst = 1'b1;
        check_frame("restart", zero_a, zero_b, SEP, SEP, -1, 7'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
